vram_arbiter: RTL and testbench

Single-port framebuffer (VRAM) arbiter between the VGA scanout and the CPU bus. Every cycle it grants the one synchronous RAM port to the scanout fetch (fixed top priority) or to the one outstanding CPU read/write. The CPU is therefore served in slots the scanout leaves free, mainly horizontal and vertical blanking. Sits between the VGA timing block, the CPU load/store path and the VRAM macro.

---
 rtl/vram_pkg.sv | 10 +
 rtl/vram_addr_gen.sv | 26 ++
 rtl/vram_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_vram_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared state type and default framebuffer geometry for the VRAM arbiter.
package vram_pkg;
    localparam int H_SIZE_DEF  = 640;
    localparam int V_SIZE_DEF  = 480;
    localparam int ADDR_W_DEF  = 19;
    localparam int DATA_W_DEF  = 8;
    localparam int FB_SIZE_DEF = H_SIZE_DEF * V_SIZE_DEF;

    typedef enum logic [1:0] {IDLE, PEND, RDW, ACK} cpu_state_t;
endpackage

// File: rtl/vram_addr_gen.sv
// Maps (x, y) to a linear framebuffer address and flags out-of-range
// coordinates; also bounds-checks a linear CPU address against the framebuffer.
module vram_addr_gen
    import vram_pkg::*;
#(
    parameter int H_SIZE = H_SIZE_DEF,
    parameter int V_SIZE = V_SIZE_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic [ADDR_W-1:0] lin_addr,
    output logic [ADDR_W-1:0] xy_addr,
    output logic              xy_oor,
    output logic              lin_oor
);
    localparam logic [ADDR_W-1:0] H_LIM  = ADDR_W'(H_SIZE);
    localparam logic [ADDR_W-1:0] FB_LIM = ADDR_W'(H_SIZE * V_SIZE);
    localparam logic [10:0]       X_LIM  = 11'(H_SIZE);
    localparam logic [10:0]       Y_LIM  = 11'(V_SIZE);

    // Product kept at ADDR_W bits; cannot overflow for in-range coordinates.
    assign xy_addr = ADDR_W'(y) * H_LIM + ADDR_W'(x);
    assign xy_oor  = ({1'b0, x} >= X_LIM) || ({1'b0, y} >= Y_LIM);
    assign lin_oor = (lin_addr >= FB_LIM);
endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VGA scanout has fixed priority, the CPU gets free slots.
// Build option: VRAM_WRITE_BUF_EN adds a one-entry posted write buffer.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int H_SIZE = H_SIZE_DEF,
    parameter int V_SIZE = V_SIZE_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vga_fetch,
    input  logic [9:0]        vga_x,
    input  logic [9:0]        vga_y,
    output logic [DATA_W-1:0] vga_col,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    cpu_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] xy_addr;
    logic              xy_oor, cpu_oor;
    logic              vga_hit, slot_free;
    logic              capture, issue_rd, issue_wr;
    logic              op_we_reg, op_oor_reg;
    logic [ADDR_W-1:0] op_addr_reg;
    logic [DATA_W-1:0] op_wdata_reg;
    logic              p1_fetch_reg, p1_hit_reg, p2_fetch_reg, p2_hit_reg;

    vram_addr_gen #(
        .H_SIZE (H_SIZE),
        .V_SIZE (V_SIZE),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .x        (vga_x),
        .y        (vga_y),
        .lin_addr (cpu_addr),
        .xy_addr  (xy_addr),
        .xy_oor   (xy_oor),
        .lin_oor  (cpu_oor)
    );

    assign vga_hit   = vga_fetch && !xy_oor;
    assign slot_free = !vga_hit;

`ifdef VRAM_WRITE_BUF_EN
    logic              buf_valid_reg;
    logic [ADDR_W-1:0] buf_addr_reg;
    logic [DATA_W-1:0] buf_wdata_reg;
    logic              buf_load_cpu, buf_load_op, buf_drain;

    assign buf_drain = buf_valid_reg && slot_free;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        issue_rd   = 1'b0;
        issue_wr   = 1'b0;
`ifdef VRAM_WRITE_BUF_EN
        buf_load_cpu = 1'b0;
        buf_load_op  = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                // cpu_ack high means the master is still showing the finished request.
                if (cpu_req && !cpu_ack) begin
                    capture    = 1'b1;
                    state_next = PEND;
`ifdef VRAM_WRITE_BUF_EN
                    if (cpu_we && !buf_valid_reg) begin
                        buf_load_cpu = !cpu_oor;
                        state_next   = ACK;
                    end
`endif
                end
            end
            PEND: begin
                if (op_oor_reg) begin
                    state_next = ACK;
`ifdef VRAM_WRITE_BUF_EN
                end else if (buf_valid_reg) begin
                    state_next = PEND;
                end else if (op_we_reg) begin
                    buf_load_op = 1'b1;
                    state_next  = ACK;
`else
                end else if (slot_free && op_we_reg) begin
                    issue_wr   = 1'b1;
                    state_next = ACK;
`endif
                end else if (slot_free) begin
                    issue_rd   = 1'b1;
                    state_next = RDW;
                end
            end
            RDW:     state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr     <= '0;
            mem_we       <= 1'b0;
            mem_wdata    <= '0;
            cpu_ack      <= 1'b0;
            cpu_rdata    <= '0;
            vga_col      <= '0;
            op_we_reg    <= 1'b0;
            op_oor_reg   <= 1'b0;
            op_addr_reg  <= '0;
            op_wdata_reg <= '0;
            p1_fetch_reg <= 1'b0;
            p1_hit_reg   <= 1'b0;
            p2_fetch_reg <= 1'b0;
            p2_hit_reg   <= 1'b0;
        end else begin
            mem_we  <= 1'b0;
            cpu_ack <= (state_reg == ACK);

            if (vga_hit) begin
                mem_addr <= xy_addr;
            end else if (issue_rd || issue_wr) begin
                mem_addr  <= op_addr_reg;
                mem_we    <= issue_wr;
                mem_wdata <= op_wdata_reg;
`ifdef VRAM_WRITE_BUF_EN
            end else if (buf_drain) begin
                mem_addr  <= buf_addr_reg;
                mem_we    <= 1'b1;
                mem_wdata <= buf_wdata_reg;
`endif
            end

            if (capture) begin
                op_we_reg    <= cpu_we;
                op_oor_reg   <= cpu_oor;
                op_addr_reg  <= cpu_addr;
                op_wdata_reg <= cpu_wdata;
            end

            // Read data arrives the cycle after RDW, so it is taken on leaving ACK.
            if (state_reg == ACK && !op_we_reg)
                cpu_rdata <= op_oor_reg ? '0 : mem_rdata;

            p1_fetch_reg <= vga_fetch;
            p1_hit_reg   <= vga_hit;
            p2_fetch_reg <= p1_fetch_reg;
            p2_hit_reg   <= p1_hit_reg;
            if (p2_fetch_reg)
                vga_col <= p2_hit_reg ? mem_rdata : '0;
        end
    end

`ifdef VRAM_WRITE_BUF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_valid_reg <= 1'b0;
            buf_addr_reg  <= '0;
            buf_wdata_reg <= '0;
        end else if (buf_load_cpu) begin
            buf_valid_reg <= 1'b1;
            buf_addr_reg  <= cpu_addr;
            buf_wdata_reg <= cpu_wdata;
        end else if (buf_load_op) begin
            buf_valid_reg <= 1'b1;
            buf_addr_reg  <= op_addr_reg;
            buf_wdata_reg <= op_wdata_reg;
        end else if (buf_drain) begin
            buf_valid_reg <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: vector tables plus multi-cycle sequences.
module tb_vram_arbiter;
    localparam int FB = 640 * 480;
`ifdef VRAM_WRITE_BUF_EN
    localparam int WL = 1;
`else
    localparam int WL = 2;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        vga_fetch;
    logic [9:0]  vga_x, vga_y;
    logic [7:0]  vga_col;
    logic        cpu_req, cpu_we;
    logic [18:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        cpu_ack;
    logic [18:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    logic [18:0] wr_addr;
    logic [7:0]  wr_data;

    logic [7:0] ram [0:FB-1];
    bit         written [0:FB-1];

    vram_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .vga_fetch (vga_fetch),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_col   (vga_col),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix(input int a);
        return 8'(a ^ (a >> 8) ^ 8'h3C);
    endfunction

    // Synchronous read-first VRAM; unwritten cells hold the pix() pattern.
    always @(posedge clk) begin
        if (int'(mem_addr) < FB) begin
            if (mem_we) begin
                ram[mem_addr]     <= mem_wdata;
                written[mem_addr] <= 1'b1;
            end
            mem_rdata <= written[mem_addr] ? ram[mem_addr] : pix(int'(mem_addr));
        end else begin
            mem_rdata <= 8'hEE;
        end
    end

    always @(negedge clk) begin
        if (mem_we) begin
            wr_cnt  = wr_cnt + 1;
            wr_addr = mem_addr;
            wr_data = mem_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cpu_op(input bit we, input logic [18:0] addr, input logic [7:0] wd,
                          output int lat, output logic [7:0] rd);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        lat = -1;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            lat++;
            if (cpu_ack) break;
        end
        rd = cpu_rdata;
        check("cpu_ack_seen", cpu_ack, 1);
        @(negedge clk);
        cpu_req = 1'b0;
    endtask

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        bit          hit;
        logic [18:0] addr;
    } vga_vec_t;

    typedef struct {
        bit          we;
        logic [18:0] addr;
        logic [7:0]  wd;
        int          lat;
        logic [7:0]  rd;
        int          nwr;
    } cpu_vec_t;

    vga_vec_t vtab [8];
    cpu_vec_t ctab [7];

    initial begin
        int lat, w0, acks;
        logic [7:0] rd;
        bit ack1, ack2;

        vtab[0] = '{10'd0,    10'd0,    1'b1, 19'd0};
        vtab[1] = '{10'd639,  10'd479,  1'b1, 19'd307199};
        vtab[2] = '{10'd640,  10'd0,    1'b0, 19'd0};
        vtab[3] = '{10'd100,  10'd1,    1'b1, 19'd740};
        vtab[4] = '{10'd0,    10'd480,  1'b0, 19'd0};
        vtab[5] = '{10'd5,    10'd2,    1'b1, 19'd1285};
        vtab[6] = '{10'd1023, 10'd1023, 1'b0, 19'd0};
        vtab[7] = '{10'd0,    10'd479,  1'b1, 19'd306560};

        ctab[0] = '{1'b1, 19'd100,    8'hA5, WL, 8'h00, 1};
        ctab[1] = '{1'b0, 19'd100,    8'h00, 3,  8'hA5, 0};
        ctab[2] = '{1'b0, 19'd307199, 8'h00, 3,  8'h6C, 0};
        ctab[3] = '{1'b0, 19'd307200, 8'h00, 2,  8'h00, 0};
        ctab[4] = '{1'b1, 19'd307200, 8'hFF, WL, 8'h00, 0};
        ctab[5] = '{1'b1, 19'd0,      8'h11, WL, 8'h00, 1};
        ctab[6] = '{1'b0, 19'd0,      8'h00, 3,  8'h11, 0};

        reset = 1'b1; vga_fetch = 1'b0; vga_x = '0; vga_y = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vga_col", vga_col, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ack", cpu_ack, 0);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vga_fetch = 1'b1; vga_x = vtab[i].x; vga_y = vtab[i].y;
            @(posedge clk); #1;
            if (vtab[i].hit) check("vga_addr", mem_addr, vtab[i].addr);
            check("vga_no_we", mem_we, 0);
            @(negedge clk); vga_fetch = 1'b0;
            @(posedge clk); @(posedge clk); #1;
            check("vga_col", vga_col, vtab[i].hit ? pix(int'(vtab[i].addr)) : 8'h00);
        end

        for (int i = 0; i < 7; i++) begin
            w0 = wr_cnt;
            cpu_op(ctab[i].we, ctab[i].addr, ctab[i].wd, lat, rd);
            repeat (3) @(posedge clk);
            #1;
            check("cpu_lat", lat, ctab[i].lat);
            if (!ctab[i].we) check("cpu_rdata", rd, ctab[i].rd);
            check("cpu_nwrites", wr_cnt - w0, ctab[i].nwr);
            if (ctab[i].nwr != 0) begin
                check("cpu_wr_addr", wr_addr, ctab[i].addr);
                check("cpu_wr_data", wr_data, ctab[i].wd);
            end
        end

        // x=640 frees the slot for a pending CPU write.
        @(negedge clk);
        vga_fetch = 1'b1; vga_x = 10'd5; vga_y = 10'd0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'd300; cpu_wdata = 8'h77;
        @(posedge clk); #1;
        check("slot_vga_addr", mem_addr, 5);
        check("slot_vga_no_we", mem_we, 0);
        @(negedge clk); vga_x = 10'd640;
        @(posedge clk); #1;
        check("slot_cpu_we", mem_we, 1);
        check("slot_cpu_addr", mem_addr, 300);
        check("slot_cpu_wdata", mem_wdata, 8'h77);
        ack1 = cpu_ack;
        @(negedge clk); vga_fetch = 1'b0;
        @(posedge clk); #1;
        check("slot_vga_col_hit", vga_col, pix(5));
        ack2 = cpu_ack;
        @(negedge clk); cpu_req = 1'b0;
        @(posedge clk); #1;
        check("slot_vga_col_oor", vga_col, 0);
        check("slot_ack_timing", {ack1, ack2}, (WL == 1) ? 2'b10 : 2'b01);

        // Full active line with a CPU read pending throughout.
        @(negedge clk);
        vga_fetch = 1'b1; vga_x = 10'd0; vga_y = 10'd10;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'd2000;
        acks = 0; w0 = 0;
        for (int i = 0; i < 640; i++) begin
            @(posedge clk); #1;
            if (cpu_ack) acks++;
            if (i >= 2 && vga_col !== pix(6400 + i - 2)) w0++;
            @(negedge clk);
            if (i < 639) vga_x = 10'(i + 1);
            else         vga_fetch = 1'b0;
        end
        check("line_no_cpu_grant", acks, 0);
        check("line_stream_errs", w0, 0);
        @(posedge clk); #1;
        check("line_cpu_granted", mem_addr, 2000);
        check("line_col_638", vga_col, pix(6400 + 638));
        @(posedge clk); #1;
        check("line_col_639", vga_col, pix(6400 + 639));
        check("line_ack_early", cpu_ack, 0);
        @(posedge clk); #1;
        check("line_ack", cpu_ack, 1);
        check("line_rdata", cpu_rdata, pix(2000));
        @(negedge clk); cpu_req = 1'b0;
        repeat (2) @(posedge clk);

        // Reset while the read sits in RDW.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'd100;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rdw_issued", mem_addr, 100);
        reset = 1'b1;
        #1;
        check("rdw_rst_mem_addr", mem_addr, 0);
        check("rdw_rst_cpu_rdata", cpu_rdata, 0);
        check("rdw_rst_mem_wdata", mem_wdata, 0);
        check("rdw_rst_vga_col", vga_col, 0);
        check("rdw_rst_ack_we", {cpu_ack, mem_we}, 0);
        cpu_req = 1'b0;
        @(negedge clk); @(negedge clk); reset = 1'b0;
        acks = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (cpu_ack) acks++;
        end
        check("rdw_no_ack", acks, 0);
        cpu_op(1'b0, 19'd100, 8'h00, lat, rd);
        check("rdw_after_lat", lat, 3);
        check("rdw_after_rdata", rd, 8'hA5);

        // Write then read during an active line.
        w0 = wr_cnt;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    vga_fetch = 1'b1; vga_x = 10'(i); vga_y = 10'd3;
                end
                @(negedge clk); vga_fetch = 1'b0;
            end
            begin
                cpu_op(1'b1, 19'd5, 8'h3C, lat, rd);
`ifdef VRAM_WRITE_BUF_EN
                check("wbuf_write_lat", lat, 1);
`endif
                cpu_op(1'b0, 19'd5, 8'h00, lat, rd);
`ifdef VRAM_WRITE_BUF_EN
                check("wbuf_read_waits", lat > 10, 1);
`endif
                check("raw_rdata", rd, 8'h3C);
            end
        join
        repeat (3) @(posedge clk);
        #1;
        check("raw_nwrites", wr_cnt - w0, 1);
        check("raw_wr_addr", wr_addr, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
